// File: rtl/lsu_mem_sequencer_if.sv
// Data-memory bus between the load/store sequencer and the memory port.
// Request side (req/we/addr/be/wdata) plus grant and read-response return.
interface lsu_mem_sequencer_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_be,
        output dmem_wdata,
        input  dmem_gnt,
        input  dmem_rvalid,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_be,
        input  dmem_wdata,
        output dmem_gnt,
        output dmem_rvalid,
        output dmem_rdata
    );
endinterface

// File: rtl/lsu_mem_sequencer.sv
// Load/store sequencer: accepts one memory op from execute, checks alignment,
// runs a req/gnt + rvalid transaction on the data bus, stalls the pipeline while
// the op is outstanding, and returns extended load data or an exception pulse.
module lsu_mem_sequencer #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    output logic        stall,
    lsu_mem_sequencer_if.master dmem,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_addr
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_REQ      = 2'd1;
    localparam logic [1:0] S_WAIT_RSP = 2'd2;
    localparam logic [1:0] S_RESP     = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] CAUSE_LOAD_MIS  = 2'b01;
    localparam logic [1:0] CAUSE_STORE_MIS = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT   = 2'b11;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [31:0]   addr_latched;
    logic [1:0]    size_latched;
    logic          unsigned_latched;
    logic [4:0]    rd_latched;

    logic          accept;
    logic          is_load;
    logic [1:0]    size_dec;
    logic          misaligned;
    logic [3:0]    be_dec;
    logic [31:0]   wdata_dec;

    logic [7:0]    byte_lane;
    logic [15:0]   half_lane;
    logic [31:0]   load_ext;
    logic [CW-1:0] cnt_inc;

    // Decode the incoming op: size (illegal encodings fall back to word), alignment, lanes
    always_comb begin
        is_load = ex_mem_read;
        accept  = (state == S_IDLE) && ex_valid && (ex_mem_read || ex_mem_write);

        size_dec = SZ_WORD;
        if (ex_funct3 == 3'b000 || (is_load && ex_funct3 == 3'b100)) begin
            size_dec = SZ_BYTE;
        end else if (ex_funct3 == 3'b001 || (is_load && ex_funct3 == 3'b101)) begin
            size_dec = SZ_HALF;
        end

        misaligned = ((size_dec == SZ_HALF) && ex_addr[0]) ||
                     ((size_dec == SZ_WORD) && (ex_addr[1:0] != 2'b00));

        be_dec    = 4'b1111;
        wdata_dec = ex_wdata;
        case (size_dec)
            SZ_BYTE: begin
                be_dec    = 4'b0001 << ex_addr[1:0];
                wdata_dec = {4{ex_wdata[7:0]}};
            end
            SZ_HALF: begin
                be_dec    = ex_addr[1] ? 4'b1100 : 4'b0011;
                wdata_dec = {2{ex_wdata[15:0]}};
            end
            default: begin
                be_dec    = 4'b1111;
                wdata_dec = ex_wdata;
            end
        endcase
    end

    // Hold upstream while a legal op is being accepted or is on the bus
    always_comb begin
        stall = (accept && !misaligned) || (state == S_REQ) || (state == S_WAIT_RSP);
    end

    // Pick the addressed lane from read data and sign/zero extend it
    always_comb begin
        byte_lane = 8'h00;
        case (addr_latched[1:0])
            2'd0:    byte_lane = dmem.dmem_rdata[7:0];
            2'd1:    byte_lane = dmem.dmem_rdata[15:8];
            2'd2:    byte_lane = dmem.dmem_rdata[23:16];
            default: byte_lane = dmem.dmem_rdata[31:24];
        endcase
        half_lane = addr_latched[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];

        load_ext = dmem.dmem_rdata;
        case (size_latched)
            SZ_BYTE: load_ext = unsigned_latched ? {24'h0, byte_lane}
                                                 : {{24{byte_lane[7]}}, byte_lane};
            SZ_HALF: load_ext = unsigned_latched ? {16'h0, half_lane}
                                                 : {{16{half_lane[15]}}, half_lane};
            default: load_ext = dmem.dmem_rdata;
        endcase
    end

    // Saturating timeout count so a grant on the last cycle cannot wrap past the limit
    always_comb begin
        cnt_inc = (cnt == CNT_LAST) ? cnt : cnt + CW'(1);
    end

    // Sequencer FSM with registered bus, writeback and exception outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            cnt              <= '0;
            addr_latched     <= '0;
            size_latched     <= SZ_BYTE;
            unsigned_latched <= 1'b0;
            rd_latched       <= '0;
            dmem.dmem_req    <= 1'b0;
            dmem.dmem_we     <= 1'b0;
            dmem.dmem_addr   <= '0;
            dmem.dmem_be     <= '0;
            dmem.dmem_wdata  <= '0;
            wb_valid         <= 1'b0;
            wb_rd            <= '0;
            wb_data          <= '0;
            exc_valid        <= 1'b0;
            exc_cause        <= '0;
            exc_addr         <= '0;
        end else begin
            wb_valid  <= 1'b0;
            exc_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (misaligned) begin
                            exc_valid <= 1'b1;
                            exc_cause <= is_load ? CAUSE_LOAD_MIS : CAUSE_STORE_MIS;
                            exc_addr  <= ex_addr;
                        end else begin
                            state            <= S_REQ;
                            cnt              <= '0;
                            addr_latched     <= ex_addr;
                            size_latched     <= size_dec;
                            unsigned_latched <= ex_funct3[2];
                            rd_latched       <= ex_rd;
                            dmem.dmem_req    <= 1'b1;
                            dmem.dmem_we     <= !is_load;
                            dmem.dmem_addr   <= {ex_addr[31:2], 2'b00};
                            dmem.dmem_be     <= be_dec;
                            dmem.dmem_wdata  <= wdata_dec;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem.dmem_gnt) begin
                        dmem.dmem_req <= 1'b0;
                        cnt           <= cnt_inc;
                        state         <= dmem.dmem_we ? S_IDLE : S_WAIT_RSP;
                    end else if (cnt == CNT_LAST) begin
                        dmem.dmem_req <= 1'b0;
                        state         <= S_IDLE;
                        exc_valid     <= 1'b1;
                        exc_cause     <= CAUSE_TIMEOUT;
                        exc_addr      <= addr_latched;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_WAIT_RSP: begin
                    if (dmem.dmem_rvalid) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_latched;
                        wb_data  <= load_ext;
                        state    <= S_RESP;
                    end else if (cnt == CNT_LAST) begin
                        state     <= S_IDLE;
                        exc_valid <= 1'b1;
                        exc_cause <= CAUSE_TIMEOUT;
                        exc_addr  <= addr_latched;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Directed bench for lsu_mem_sequencer: loads, lane extraction, delayed-grant
// store, misalignment, bus timeout and reset during an outstanding load.
module tb_lsu_mem_sequencer;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [31:0] exc_addr;

    int errors = 0;
    int checks = 0;

    lsu_mem_sequencer_if bus();

    lsu_mem_sequencer #(.TIMEOUT(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_funct3    (ex_funct3),
        .ex_addr      (ex_addr),
        .ex_wdata     (ex_wdata),
        .ex_rd        (ex_rd),
        .stall        (stall),
        .dmem         (bus.master),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .exc_valid    (exc_valid),
        .exc_cause    (exc_cause),
        .exc_addr     (exc_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        ex_valid     = 1'b1;
        ex_mem_read  = rd_op;
        ex_mem_write = wr_op;
        ex_funct3    = f3;
        ex_addr      = a;
        ex_wdata     = wd;
        ex_rd        = rd;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be, bus.dmem_wdata} !== 70'd0) begin
            errors++;
            $display("FAIL reset_bus: got req=%b we=%b addr=%h be=%b wdata=%h, expected all 0",
                     bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be, bus.dmem_wdata);
        end
        checks++;
        if ({wb_valid, wb_rd, wb_data, exc_valid, exc_cause, exc_addr} !== 73'd0) begin
            errors++;
            $display("FAIL reset_wb_exc: got wbv=%b rd=%0d data=%h excv=%b cause=%b eaddr=%h, expected all 0",
                     wb_valid, wb_rd, wb_data, exc_valid, exc_cause, exc_addr);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %b expected 0", stall);
        end
        rst_n = 1'b1;
        tick();
        $display("reset: released");
    endtask

    task automatic test_lw_basic();
        int stall_cycles;
        stall_cycles = 0;
        // cycle 0: accept
        drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd5);
        @(negedge clk);
        if (stall === 1'b1) stall_cycles++;
        checks++;
        if (bus.dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL lw_req_c0: got %b expected 0", bus.dmem_req);
        end
        tick();
        // cycle 1: request, granted immediately
        bus.dmem_gnt = 1'b1;
        @(negedge clk);
        if (stall === 1'b1) stall_cycles++;
        checks++;
        if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be} !== {1'b1, 1'b0, 32'h0000_0100, 4'b1111}) begin
            errors++;
            $display("FAIL lw_bus_c1: got req=%b we=%b addr=%h be=%b expected 1 0 00000100 1111",
                     bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be);
        end
        tick();
        // cycle 2: response
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        if (stall === 1'b1) stall_cycles++;
        checks++;
        if ({bus.dmem_req, wb_valid} !== 2'b00) begin
            errors++;
            $display("FAIL lw_c2: got req=%b wb_valid=%b expected 0 0", bus.dmem_req, wb_valid);
        end
        tick();
        // cycle 3: writeback; the load leaves execute
        bus.dmem_rvalid = 1'b0;
        ex_valid        = 1'b0;
        @(negedge clk);
        if (stall === 1'b1) stall_cycles++;
        checks++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL lw_wb: got valid=%b rd=%0d data=%h expected 1 5 deadbeef",
                     wb_valid, wb_rd, wb_data);
        end
        tick();
        @(negedge clk);
        if (stall === 1'b1) stall_cycles++;
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL lw_wb_pulse: got wb_valid=%b expected 0 one cycle later", wb_valid);
        end
        checks++;
        if (stall_cycles != 3) begin
            errors++;
            $display("FAIL lw_stall_len: got %0d stall cycles expected 3", stall_cycles);
        end
        tick();
        $display("lw_basic: addr=00000100 wb_data=%h stall_cycles=%0d", wb_data, stall_cycles);
    endtask

    task automatic test_load_extract();
        logic [2:0]  f3_t   [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] addr_t [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
        logic [3:0]  be_t   [4] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011};
        logic [31:0] exp_t  [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_FF12};
        for (int i = 0; i < 4; i++) begin
            drive_op(1'b1, 1'b0, f3_t[i], addr_t[i], 32'h0, 5'd9);
            tick();
            bus.dmem_gnt = 1'b1;
            @(negedge clk);
            checks++;
            if (bus.dmem_be !== be_t[i]) begin
                errors++;
                $display("FAIL ld_be[%0d]: got %b expected %b", i, bus.dmem_be, be_t[i]);
            end
            tick();
            bus.dmem_gnt    = 1'b0;
            bus.dmem_rvalid = 1'b1;
            bus.dmem_rdata  = 32'h80FF_FF12;
            tick();
            bus.dmem_rvalid = 1'b0;
            ex_valid        = 1'b0;
            @(negedge clk);
            checks++;
            if ({wb_valid, wb_data} !== {1'b1, exp_t[i]}) begin
                errors++;
                $display("FAIL ld_ext[%0d]: got valid=%b data=%h expected 1 %h",
                         i, wb_valid, wb_data, exp_t[i]);
            end
            tick();
            $display("load_extract: funct3=%b addr=%h wb_data=%h", f3_t[i], addr_t[i], wb_data);
        end
    endtask

    task automatic test_store_delayed();
        int wb_seen;
        wb_seen = 0;
        drive_op(1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h1234_56AB, 5'd0);
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL sb_stall_c0: got %b expected 1", stall);
        end
        tick();
        for (int c = 1; c <= 5; c++) begin
            bus.dmem_gnt = (c == 5);
            @(negedge clk);
            if (wb_valid === 1'b1) wb_seen++;
            checks++;
            if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be, bus.dmem_wdata, stall} !==
                {1'b1, 1'b1, 32'h0000_0200, 4'b0010, 32'hABAB_ABAB, 1'b1}) begin
                errors++;
                $display("FAIL sb_hold_c%0d: got req=%b we=%b addr=%h be=%b wdata=%h stall=%b expected 1 1 00000200 0010 abababab 1",
                         c, bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be, bus.dmem_wdata, stall);
            end
            tick();
        end
        bus.dmem_gnt = 1'b0;
        ex_valid     = 1'b0;
        @(negedge clk);
        if (wb_valid === 1'b1) wb_seen++;
        checks++;
        if ({bus.dmem_req, stall} !== 2'b00) begin
            errors++;
            $display("FAIL sb_done: got req=%b stall=%b expected 0 0", bus.dmem_req, stall);
        end
        checks++;
        if (wb_seen != 0) begin
            errors++;
            $display("FAIL sb_no_wb: got %0d wb pulses expected 0", wb_seen);
        end
        tick();
        $display("store_delayed: addr=00000200 be=0010 wdata=abababab wb_pulses=%0d", wb_seen);
    endtask

    task automatic test_misaligned();
        logic        rd_t   [2] = '{1'b1, 1'b0};
        logic [2:0]  f3_t   [2] = '{3'b010, 3'b001};
        logic [31:0] addr_t [2] = '{32'h0000_0102, 32'h0000_0301};
        logic [1:0]  cau_t  [2] = '{2'b01, 2'b10};
        for (int i = 0; i < 2; i++) begin
            drive_op(rd_t[i], !rd_t[i], f3_t[i], addr_t[i], 32'h5555_AAAA, 5'd1);
            @(negedge clk);
            checks++;
            if ({stall, bus.dmem_req} !== 2'b00) begin
                errors++;
                $display("FAIL mis_nobus[%0d]: got stall=%b req=%b expected 0 0", i, stall, bus.dmem_req);
            end
            tick();
            ex_valid = 1'b0;
            @(negedge clk);
            checks++;
            if ({exc_valid, exc_cause, exc_addr, bus.dmem_req} !== {1'b1, cau_t[i], addr_t[i], 1'b0}) begin
                errors++;
                $display("FAIL mis_exc[%0d]: got valid=%b cause=%b addr=%h req=%b expected 1 %b %h 0",
                         i, exc_valid, exc_cause, exc_addr, bus.dmem_req, cau_t[i], addr_t[i]);
            end
            tick();
            @(negedge clk);
            checks++;
            if (exc_valid !== 1'b0) begin
                errors++;
                $display("FAIL mis_pulse[%0d]: got exc_valid=%b expected 0", i, exc_valid);
            end
            tick();
            $display("misaligned: addr=%h cause=%b", addr_t[i], cau_t[i]);
        end
    endtask

    task automatic test_timeout();
        int req_cycles;
        req_cycles = 0;
        drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd4);
        tick();
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.dmem_req === 1'b1) req_cycles++;
            tick();
        end
        ex_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (req_cycles != 8 || bus.dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL to_req_len: got %0d req cycles (req now %b) expected 8 (0)", req_cycles, bus.dmem_req);
        end
        checks++;
        if ({exc_valid, exc_cause, exc_addr} !== {1'b1, 2'b11, 32'h0000_0400}) begin
            errors++;
            $display("FAIL to_exc: got valid=%b cause=%b addr=%h expected 1 11 00000400",
                     exc_valid, exc_cause, exc_addr);
        end
        tick();
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'hCAFE_F00D;
        tick();
        bus.dmem_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({wb_valid, exc_valid, stall} !== 3'b000) begin
            errors++;
            $display("FAIL to_late_rvalid: got wb_valid=%b exc_valid=%b stall=%b expected 0 0 0",
                     wb_valid, exc_valid, stall);
        end
        tick();
        $display("timeout: req_cycles=%0d cause=%b", req_cycles, exc_cause);
    endtask

    task automatic test_reset_mid();
        drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 5'd3);
        tick();
        bus.dmem_gnt = 1'b1;
        tick();
        bus.dmem_gnt = 1'b0;
        rst_n        = 1'b0;
        ex_valid     = 1'b0;
        #1;
        checks++;
        if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be, bus.dmem_wdata,
             wb_valid, wb_rd, wb_data, exc_valid, exc_cause, exc_addr, stall} !== 144'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got req=%b addr=%h be=%b wbv=%b wbd=%h excv=%b stall=%b expected all 0",
                     bus.dmem_req, bus.dmem_addr, bus.dmem_be, wb_valid, wb_data, exc_valid, stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h1111_2222;
        tick();
        bus.dmem_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({wb_valid, exc_valid} !== 2'b00) begin
            errors++;
            $display("FAIL rst_stale_rvalid: got wb_valid=%b exc_valid=%b expected 0 0", wb_valid, exc_valid);
        end
        tick();
        drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'h0, 5'd7);
        tick();
        bus.dmem_gnt = 1'b1;
        tick();
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h1357_9BDF;
        tick();
        bus.dmem_rvalid = 1'b0;
        ex_valid        = 1'b0;
        @(negedge clk);
        checks++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd7, 32'h1357_9BDF}) begin
            errors++;
            $display("FAIL rst_next_lw: got valid=%b rd=%0d data=%h expected 1 7 13579bdf",
                     wb_valid, wb_rd, wb_data);
        end
        tick();
        $display("reset_mid: next lw wb_data=%h", wb_data);
    endtask

    initial begin
        rst_n           = 1'b0;
        ex_valid        = 1'b0;
        ex_mem_read     = 1'b0;
        ex_mem_write    = 1'b0;
        ex_funct3       = 3'b000;
        ex_addr         = 32'h0;
        ex_wdata        = 32'h0;
        ex_rd           = 5'd0;
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = 32'h0;
        repeat (2) @(posedge clk);
        test_reset();
        test_lw_basic();
        test_load_extract();
        test_store_delayed();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
